stage_reg_gen: RTL and testbench
================================

Name: stage_reg_gen

Overview:
Parametrised pipeline boundary register, the next generation of the fixed-width MEM/WB latch. It carries N write-back lanes plus an optional HI/LO pair from one stage to the next. The register responds to the ctrl stall vector at a configurable stage index, to a pipeline flush, and to same-cycle write conflicts between lanes. It also keeps saturating bubble/hold performance counters for the ctrl and debug path.

Parameters:
NUM_LANES, 1, number of parallel register-write lanes (1..4)
ADDR_W, 5, register address width
DATA_W, 32, register data width
HILO_EN, 1, 1 = instantiate HI/LO channel; 0 = HI/LO outputs tied to zero
STAGE, 4, index of this boundary in the stall vector
STALL_W, 6, stall vector width
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
stall  in  STALL_W  ctrl stall vector
flush  in  1  discard the captured contents and insert a NOP
clr_cnt  in  1  synchronous clear of both counters
in_wreg  in  NUM_LANES  per-lane write enable
in_waddr  in  NUM_LANES*ADDR_W  per-lane destination; lane i occupies [i*ADDR_W +: ADDR_W]
in_wdata  in  NUM_LANES*DATA_W  per-lane data
in_whilo  in  1  HI/LO write enable
in_hi  in  DATA_W  HI value
in_lo  in  DATA_W  LO value
out_wreg  out  NUM_LANES  registered write enables
out_waddr  out  NUM_LANES*ADDR_W  registered destinations
out_wdata  out  NUM_LANES*DATA_W  registered data
out_whilo  out  1  registered HI/LO enable
out_hi  out  DATA_W  registered HI
out_lo  out  DATA_W  registered LO
bubble_cnt  out  CNT_W  number of NOP-insert cycles (bubble or flush)
hold_cnt  out  CNT_W  number of hold cycles

Behaviour:
- Reset: rst low clears every out_* and both counters to 0 immediately, without waiting for clk. Release is synchronised externally.
- Define stall_here = stall[STAGE].
- Define stall_next = stall[STAGE+1]. When STAGE = STALL_W-1, stall_next is the constant 0.
- Per-edge action, highest priority first:
  1. flush=1: load NOP (all enables, addresses and data = 0).
  2. stall_here=1 and stall_next=0: load NOP (bubble).
  3. stall_here=0: capture the inputs (advance).
  4. Otherwise (stall_here=1 and stall_next=1): hold all outputs.
- Latency: one cycle from input to output on advance.
- Zero-register suppression on capture: a lane with in_waddr==0 is captured with out_wreg=0. Its address and data are still captured.
- WAW resolution on capture: if lanes i<j both have in_wreg=1 and equal nonzero in_waddr, lane i is captured with out_wreg=0. The highest-index lane wins. The check covers all pairs and is combinational before the register.
- HILO_EN=0: out_whilo, out_hi and out_lo are constant 0. in_* HI/LO ports are ignored.
- bubble_cnt: increments on each edge taking action 1 or 2.
- hold_cnt: increments on each edge taking action 4.
- Both counters saturate at all-ones and never wrap.
- clr_cnt=1: both counters load 0 on that edge. This overrides any increment in the same cycle. clr_cnt has no effect on the data path.
- Flush during a hold overrides the hold: NOP loaded, bubble_cnt increments, hold_cnt does not.
- Reset asserted mid-stall: outputs clear at once. After release the block behaves per the current stall/flush inputs.

Decomposition:
- Shared defines package supplies:
  - Stop/NoStop encoding.
  - WriteEnable/WriteDisable encoding.
  - ZeroWord.
  - NOPRegAddr.
  - Default widths RegAddrBus and RegDataBus, from which ADDR_W and DATA_W defaults derive.
- One natural sub-module: sat_counter (parameter W; inputs inc and clr; output count), instantiated twice.
- The WAW/zero-suppress mask is a function inside stage_reg_gen.

Test Plan:
1. Reset and advance: rst low mid-cycle → all outputs 0 before the next edge. Release, then NUM_LANES=1, in_wreg=1, in_waddr=3, in_wdata=0xDEADBEEF, stall=0 → the following edge gives out_wreg=1, out_waddr=3, out_wdata=0xDEADBEEF.
2. Bubble vs hold at STAGE=4: stall=6'b010000 → NOP out, bubble_cnt=1. Then stall=6'b110000 for 3 cycles with changing inputs → outputs frozen at NOP, hold_cnt=3. Then stall=0 → new input captured.
3. Flush priority: stall=6'b110000 and flush=1 with out holding waddr 7 → next edge gives NOP, bubble_cnt+1, hold_cnt unchanged.
4. WAW and zero suppression, NUM_LANES=2:
   - lane0 (wreg=1, addr=9, data=1) and lane1 (wreg=1, addr=9, data=2) → out_wreg=2'b10.
   - lane0 addr=0 with wreg=1 → out_wreg[0]=0.
5. Counter saturation and clear, CNT_W=2: 5 bubble edges → bubble_cnt=3. clr_cnt=1 in the same cycle as a bubble → bubble_cnt=0.
6. HILO_EN=0 with in_whilo=1, in_hi=0x12345678 → out_whilo=0 and out_hi=0 in all cycles. With HILO_EN=1 the same stimulus appears on the outputs after one edge.

Source files
------------

// File: rtl/stage_reg_gen_pkg.sv
// Shared encodings and defaults for the pipeline boundary register family.
// The package also holds the per-edge action decode that every boundary uses.
package stage_reg_gen_pkg;

  localparam logic Stop         = 1'b1;
  localparam logic NoStop       = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam int RegAddrBus = 5;
  localparam int RegDataBus = 32;

  localparam logic [RegDataBus-1:0] ZeroWord   = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_FLUSH
  } stage_act_e;

  // Flush beats everything. A stall that stops here but not downstream leaves a hole,
  // and that hole is filled with a NOP.
  function automatic stage_act_e decode_action(input logic flush,
                                               input logic stall_here,
                                               input logic stall_next);
    if (flush)                                          return ACT_FLUSH;
    if (stall_here == Stop && stall_next == NoStop)     return ACT_BUBBLE;
    if (stall_here == NoStop)                           return ACT_ADVANCE;
    return ACT_HOLD;
  endfunction

endpackage

// File: rtl/stage_reg_gen_if.sv
// Bus bundle between the pipeline ctrl/producer side (master) and the boundary register (slave).
interface stage_reg_gen_if
  import stage_reg_gen_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int ADDR_W    = RegAddrBus,
  parameter int DATA_W    = RegDataBus,
  parameter int STALL_W   = 6,
  parameter int CNT_W     = 16
);
  logic [STALL_W-1:0]          stall;
  logic                        flush;
  logic                        clr_cnt;
  logic [NUM_LANES-1:0]        in_wreg;
  logic [NUM_LANES*ADDR_W-1:0] in_waddr;
  logic [NUM_LANES*DATA_W-1:0] in_wdata;
  logic                        in_whilo;
  logic [DATA_W-1:0]           in_hi;
  logic [DATA_W-1:0]           in_lo;
  logic [NUM_LANES-1:0]        out_wreg;
  logic [NUM_LANES*ADDR_W-1:0] out_waddr;
  logic [NUM_LANES*DATA_W-1:0] out_wdata;
  logic                        out_whilo;
  logic [DATA_W-1:0]           out_hi;
  logic [DATA_W-1:0]           out_lo;
  logic [CNT_W-1:0]            bubble_cnt;
  logic [CNT_W-1:0]            hold_cnt;

  modport master (
    output stall, flush, clr_cnt, in_wreg, in_waddr, in_wdata, in_whilo, in_hi, in_lo,
    input  out_wreg, out_waddr, out_wdata, out_whilo, out_hi, out_lo, bubble_cnt, hold_cnt
  );

  modport slave (
    input  stall, flush, clr_cnt, in_wreg, in_waddr, in_wdata, in_whilo, in_hi, in_lo,
    output out_wreg, out_waddr, out_wdata, out_whilo, out_hi, out_lo, bubble_cnt, hold_cnt
  );
endinterface

// File: rtl/stage_reg_gen_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q;

  // NOTE: state is updated with non-blocking assignments only, so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && count_q != '1) begin
      count_q <= count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_q;
endmodule

// File: rtl/stage_reg_gen.sv
// Parametrised pipeline boundary register with stall/flush handling, WAW and zero-register
// write suppression, optional HI/LO channel and saturating bubble/hold counters.
module stage_reg_gen
  import stage_reg_gen_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int ADDR_W    = RegAddrBus,
  parameter int DATA_W    = RegDataBus,
  parameter bit HILO_EN   = 1'b1,
  parameter int STAGE     = 4,
  parameter int STALL_W   = 6,
  parameter int CNT_W     = 16
) (
  input logic           clk,
  input logic           rst,
  stage_reg_gen_if.slave bus
);

  // A lane keeps its enable only if it targets a nonzero register and no higher lane
  // writes the same register in this cycle.
  function automatic logic [NUM_LANES-1:0] wreg_mask(
    input logic [NUM_LANES-1:0]        wreg,
    input logic [NUM_LANES*ADDR_W-1:0] waddr
  );
    logic [NUM_LANES-1:0] mask;
    for (int i = 0; i < NUM_LANES; i++) begin
      mask[i] = (wreg[i] == WriteEnable && waddr[i*ADDR_W +: ADDR_W] != '0)
                ? WriteEnable : WriteDisable;
      for (int j = i + 1; j < NUM_LANES; j++) begin
        if (wreg[j] == WriteEnable &&
            waddr[j*ADDR_W +: ADDR_W] == waddr[i*ADDR_W +: ADDR_W])
          mask[i] = WriteDisable;
      end
    end
    return mask;
  endfunction

  logic       stall_here;
  logic       stall_next;
  stage_act_e act;

  assign stall_here = bus.stall[STAGE];

  generate
    if (STAGE == STALL_W - 1) begin : g_last_stage
      assign stall_next = NoStop;
    end else begin : g_mid_stage
      assign stall_next = bus.stall[STAGE+1];
    end
  endgenerate

  assign act = decode_action(bus.flush, stall_here, stall_next);

  logic [NUM_LANES-1:0]        wreg_q;
  logic [NUM_LANES*ADDR_W-1:0] waddr_q;
  logic [NUM_LANES*DATA_W-1:0] wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wreg_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      case (act)
        ACT_FLUSH, ACT_BUBBLE: begin
          wreg_q  <= '0;
          waddr_q <= '0;
          wdata_q <= '0;
        end
        ACT_ADVANCE: begin
          wreg_q  <= wreg_mask(bus.in_wreg, bus.in_waddr);
          waddr_q <= bus.in_waddr;
          wdata_q <= bus.in_wdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_wreg  = wreg_q;
  assign bus.out_waddr = waddr_q;
  assign bus.out_wdata = wdata_q;

  generate
    if (HILO_EN) begin : g_hilo
      logic              whilo_q;
      logic [DATA_W-1:0] hi_q;
      logic [DATA_W-1:0] lo_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          whilo_q <= WriteDisable;
          hi_q    <= '0;
          lo_q    <= '0;
        end else begin
          case (act)
            ACT_FLUSH, ACT_BUBBLE: begin
              whilo_q <= WriteDisable;
              hi_q    <= '0;
              lo_q    <= '0;
            end
            ACT_ADVANCE: begin
              whilo_q <= bus.in_whilo;
              hi_q    <= bus.in_hi;
              lo_q    <= bus.in_lo;
            end
            default: ;
          endcase
        end
      end

      assign bus.out_whilo = whilo_q;
      assign bus.out_hi    = hi_q;
      assign bus.out_lo    = lo_q;
    end else begin : g_no_hilo
      assign bus.out_whilo = WriteDisable;
      assign bus.out_hi    = '0;
      assign bus.out_lo    = '0;
    end
  endgenerate

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (act == ACT_FLUSH || act == ACT_BUBBLE),
    .clr   (bus.clr_cnt),
    .count (bus.bubble_cnt)
  );

  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (act == ACT_HOLD),
    .clr   (bus.clr_cnt),
    .count (bus.hold_cnt)
  );

endmodule

// File: tb/tb_stage_reg_gen.sv
// Bench for stage_reg_gen: two configurations driven side by side and compared every cycle
// against a lane-level reference model of the boundary register.
module tb_stage_reg_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Config A: 2 lanes, HI/LO present, STAGE=4, 16-bit counters.
  // Config B: 1 lane, HI/LO absent, last stage (STAGE=5), 2-bit counters.
  stage_reg_gen_if #(.NUM_LANES(2), .ADDR_W(5), .DATA_W(32), .STALL_W(6), .CNT_W(16)) ifa ();
  stage_reg_gen_if #(.NUM_LANES(1), .ADDR_W(5), .DATA_W(32), .STALL_W(6), .CNT_W(2))  ifb ();

  stage_reg_gen #(.NUM_LANES(2), .ADDR_W(5), .DATA_W(32), .HILO_EN(1'b1), .STAGE(4),
                  .STALL_W(6), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  stage_reg_gen #(.NUM_LANES(1), .ADDR_W(5), .DATA_W(32), .HILO_EN(1'b0), .STAGE(5),
                  .STALL_W(6), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  logic [5:0]  stall;
  logic        flush;
  logic        clr_cnt;
  logic [1:0]  in_wreg;
  logic [9:0]  in_waddr;
  logic [63:0] in_wdata;
  logic        in_whilo;
  logic [31:0] in_hi;
  logic [31:0] in_lo;

  assign ifa.stall    = stall;
  assign ifa.flush    = flush;
  assign ifa.clr_cnt  = clr_cnt;
  assign ifa.in_wreg  = in_wreg;
  assign ifa.in_waddr = in_waddr;
  assign ifa.in_wdata = in_wdata;
  assign ifa.in_whilo = in_whilo;
  assign ifa.in_hi    = in_hi;
  assign ifa.in_lo    = in_lo;
  assign ifb.stall    = stall;
  assign ifb.flush    = flush;
  assign ifb.clr_cnt  = clr_cnt;
  assign ifb.in_wreg  = in_wreg[0];
  assign ifb.in_waddr = in_waddr[4:0];
  assign ifb.in_wdata = in_wdata[31:0];
  assign ifb.in_whilo = in_whilo;
  assign ifb.in_hi    = in_hi;
  assign ifb.in_lo    = in_lo;

  typedef struct {
    logic [1:0]  wreg;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    int          bub;
    int          hold;
  } mstate_t;

  mstate_t ma, mb;
  int errors = 0;
  int checks = 0;

  function automatic mstate_t zero_state();
    mstate_t z;
    z.wreg = '0; z.waddr = '0; z.wdata = '0; z.whilo = 1'b0;
    z.hi = '0; z.lo = '0; z.bub = 0; z.hold = 0;
    return z;
  endfunction

  // Expected register contents after the coming edge, given the inputs now applied.
  function automatic mstate_t model_next(mstate_t s, int nl, int stage, bit hilo, int cmax);
    mstate_t    n;
    logic [6:0] sx;
    bit         here, nxt;
    n  = s;
    sx = {1'b0, stall};
    here = sx[stage];
    nxt  = sx[stage+1];
    if (flush || (here && !nxt)) begin
      n = zero_state();
      n.hold = s.hold;
      n.bub  = (s.bub < cmax) ? s.bub + 1 : cmax;
    end else if (!here) begin
      n.wreg = '0; n.waddr = '0; n.wdata = '0;
      for (int i = 0; i < nl; i++) begin
        bit en;
        en = in_wreg[i] && (in_waddr[i*5 +: 5] != 5'd0);
        for (int j = i + 1; j < nl; j++)
          if (in_wreg[j] && in_waddr[j*5 +: 5] == in_waddr[i*5 +: 5]) en = 1'b0;
        n.wreg[i]          = en;
        n.waddr[i*5 +: 5]  = in_waddr[i*5 +: 5];
        n.wdata[i*32 +: 32] = in_wdata[i*32 +: 32];
      end
      n.whilo = hilo ? in_whilo : 1'b0;
      n.hi    = hilo ? in_hi : 32'h0;
      n.lo    = hilo ? in_lo : 32'h0;
    end else begin
      n.hold = (s.hold < cmax) ? s.hold + 1 : cmax;
    end
    if (clr_cnt) begin
      n.bub  = 0;
      n.hold = 0;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic compare_all();
    check("a.wreg",   64'(ifa.out_wreg),   64'(ma.wreg));
    check("a.waddr",  64'(ifa.out_waddr),  64'(ma.waddr));
    check("a.wdata",  ifa.out_wdata,       ma.wdata);
    check("a.whilo",  64'(ifa.out_whilo),  64'(ma.whilo));
    check("a.hi",     64'(ifa.out_hi),     64'(ma.hi));
    check("a.lo",     64'(ifa.out_lo),     64'(ma.lo));
    check("a.bubble", 64'(ifa.bubble_cnt), 64'(ma.bub));
    check("a.hold",   64'(ifa.hold_cnt),   64'(ma.hold));
    check("b.wreg",   64'(ifb.out_wreg),   64'(mb.wreg[0]));
    check("b.waddr",  64'(ifb.out_waddr),  64'(mb.waddr[4:0]));
    check("b.wdata",  64'(ifb.out_wdata),  64'(mb.wdata[31:0]));
    check("b.whilo",  64'(ifb.out_whilo),  64'(mb.whilo));
    check("b.hi",     64'(ifb.out_hi),     64'(mb.hi));
    check("b.lo",     64'(ifb.out_lo),     64'(mb.lo));
    check("b.bubble", 64'(ifb.bubble_cnt), 64'(mb.bub));
    check("b.hold",   64'(ifb.hold_cnt),   64'(mb.hold));
  endtask

  // Inputs are applied at the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    ma = model_next(ma, 2, 4, 1'b1, 65535);
    mb = model_next(mb, 1, 5, 1'b0, 3);
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stall = '0; flush = 1'b0; clr_cnt = 1'b0; in_wreg = '0; in_waddr = '0;
    in_wdata = '0; in_whilo = 1'b0; in_hi = '0; in_lo = '0;
    ma = zero_state();
    mb = zero_state();

    // Reset state
    #2 rst = 1'b0;
    @(negedge clk);
    compare_all();
    rst = 1'b1;

    // Advance, then asynchronous reset mid-cycle
    in_wreg = 2'b01; in_waddr = {5'd0, 5'd3}; in_wdata = {32'h0, 32'hDEADBEEF};
    step();
    check("t1.b_wreg",  64'(ifb.out_wreg),  64'd1);
    check("t1.b_waddr", 64'(ifb.out_waddr), 64'd3);
    check("t1.b_wdata", 64'(ifb.out_wdata), 64'hDEADBEEF);
    #2 rst = 1'b0;
    #1;
    ma = zero_state();
    mb = zero_state();
    compare_all();
    check("t1.rst_wdata", 64'(ifb.out_wdata), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Bubble, then hold with changing inputs, then advance
    stall = 6'b010000; in_wreg = 2'b11; in_waddr = {5'd5, 5'd6};
    step();
    check("t2.bubble_wreg", 64'(ifa.out_wreg),   64'd0);
    check("t2.bubble_cnt",  64'(ifa.bubble_cnt), 64'd1);
    stall = 6'b110000;
    for (int k = 0; k < 3; k++) begin
      in_wdata = {$urandom, $urandom}; in_waddr = 10'($urandom);
      step();
    end
    check("t2.hold_cnt",   64'(ifa.hold_cnt),  64'd3);
    check("t2.hold_waddr", 64'(ifa.out_waddr), 64'd0);
    stall = 6'b000000; in_wreg = 2'b01; in_waddr = {5'd2, 5'd1}; in_wdata = {32'h22, 32'h11};
    step();
    check("t2.advance_wdata", ifa.out_wdata, {32'h22, 32'h11});

    // Flush overrides hold
    in_wreg = 2'b11; in_waddr = {5'd8, 5'd7};
    step();
    stall = 6'b110000;
    step();
    check("t3.held_waddr", 64'(ifa.out_waddr[4:0]), 64'd7);
    flush = 1'b1;
    step();
    check("t3.flush_waddr", 64'(ifa.out_waddr), 64'd0);
    flush = 1'b0;

    // WAW and zero-register suppression
    stall = 6'b000000;
    in_wreg = 2'b11; in_waddr = {5'd9, 5'd9}; in_wdata = {32'd2, 32'd1};
    step();
    check("t4.waw_wreg", 64'(ifa.out_wreg), 64'b10);
    in_waddr = {5'd4, 5'd0};
    step();
    check("t4.zero_wreg", 64'(ifa.out_wreg), 64'b10);
    in_waddr = {5'd0, 5'd0};
    step();

    // Saturation and clear of the 2-bit counter on the last-stage boundary
    stall = 6'b100000;
    for (int k = 0; k < 5; k++) step();
    check("t5.sat_bubble", 64'(ifb.bubble_cnt), 64'd3);
    clr_cnt = 1'b1;
    step();
    check("t5.clr_bubble", 64'(ifb.bubble_cnt), 64'd0);
    clr_cnt = 1'b0;

    // HI/LO present vs absent
    stall = 6'b000000; in_whilo = 1'b1; in_hi = 32'h12345678; in_lo = 32'h9ABCDEF0;
    step();
    check("t6.a_hi",    64'(ifa.out_hi),    64'h12345678);
    check("t6.b_whilo", 64'(ifb.out_whilo), 64'd0);
    check("t6.b_hi",    64'(ifb.out_hi),    64'd0);

    // Reset asserted mid-stall, then resume from current inputs
    stall = 6'b110000;
    step();
    #2 rst = 1'b0;
    #1;
    ma = zero_state();
    mb = zero_state();
    compare_all();
    @(negedge clk);
    rst = 1'b1;
    step();
    step();

    // Randomised traffic with narrow address range to provoke collisions
    for (int k = 0; k < 400; k++) begin
      stall    = 6'($urandom);
      flush    = ($urandom_range(7) == 0);
      clr_cnt  = ($urandom_range(31) == 0);
      in_wreg  = 2'($urandom);
      in_waddr = {5'($urandom_range(3)), 5'($urandom_range(3))};
      in_wdata = {$urandom, $urandom};
      in_whilo = 1'($urandom);
      in_hi    = $urandom;
      in_lo    = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
